// File: rtl/fir_accumulator.sv
// fir_accumulator: sums NUM_TAPS signed products per frame, scales and saturates to 18 bits, 2-entry output FIFO.
// Define FIR_ACC_ROUND_EN to round half up before the scale shift (default build truncates).
module fir_accumulator #(
    parameter int unsigned NUM_TAPS = 16,
    parameter int unsigned SHIFT    = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic [47:0] product_in,
    input  logic        flush,
    output logic [17:0] sample_out,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic        overflow,
    output logic        saturated
);
    localparam int unsigned PW = 48;
    localparam int unsigned OW = 18;
    localparam int unsigned CW = $clog2(NUM_TAPS);
    localparam int unsigned AW = PW + CW;
    localparam int unsigned EW = AW + 1;
    localparam logic [CW-1:0]        LAST_TAP = CW'(NUM_TAPS - 1);
    localparam logic signed [EW-1:0] SAT_MAX  = EW'(131071);
    localparam logic signed [EW-1:0] SAT_MIN  = EW'(-131072);
    localparam logic [OW-1:0]        OUT_MAX  = 18'h1FFFF;
    localparam logic [OW-1:0]        OUT_MIN  = 18'h20000;
`ifdef FIR_ACC_ROUND_EN
    localparam int unsigned          RSH      = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [EW-1:0] RND      = (SHIFT > 0) ? (EW'(1) << RSH) : '0;
`endif

    logic [CW-1:0]        tap_q, tap_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 cmp_q, cmp_d;
    logic [OW-1:0]        scl_q, scl_d;
    logic                 scl_vld_q, scl_vld_d;
    logic                 scl_clip_q, scl_clip_d;
    logic [OW-1:0]        head_q, head_d, tail_q, tail_d;
    logic                 head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic                 ovf_q, ovf_d, sat_q, sat_d;
    logic signed [EW-1:0] acc_ext, shifted;
    logic                 push, pop;

    // Tap counting and accumulation; flush with valid_in starts a new frame at tap 0.
    always_comb begin
        tap_d = tap_q;
        acc_d = acc_q;
        cmp_d = 1'b0;
        if (valid_in) begin
            if (flush || (tap_q == '0)) begin
                acc_d = AW'($signed(product_in));
            end else begin
                acc_d = acc_q + AW'($signed(product_in));
            end
            if (flush) begin
                tap_d = CW'(1);
            end else if (tap_q == LAST_TAP) begin
                tap_d = '0;
                cmp_d = 1'b1;
            end else begin
                tap_d = tap_q + CW'(1);
            end
        end else if (flush) begin
            tap_d = '0;
        end
    end

    // Scale stage: shift the completed sum, then clip to the 18-bit output range.
    always_comb begin
`ifdef FIR_ACC_ROUND_EN
        acc_ext = EW'(acc_q) + RND;
`else
        acc_ext = EW'(acc_q);
`endif
        shifted    = acc_ext >>> SHIFT;
        scl_vld_d  = cmp_q;
        scl_clip_d = 1'b1;
        if (shifted > SAT_MAX) begin
            scl_d = OUT_MAX;
        end else if (shifted < SAT_MIN) begin
            scl_d = OUT_MIN;
        end else begin
            scl_d      = shifted[OW-1:0];
            scl_clip_d = 1'b0;
        end
    end

    // Two-entry FIFO: head drives the outputs directly, tail holds the second sample.
    always_comb begin
        push       = scl_vld_q;
        pop        = head_vld_q & sample_ready;
        head_d     = head_q;
        head_vld_d = head_vld_q;
        tail_d     = tail_q;
        tail_vld_d = tail_vld_q;
        ovf_d      = ovf_q;
        sat_d      = sat_q | (push & scl_clip_q);
        if (pop) begin
            head_d     = tail_q;
            head_vld_d = tail_vld_q;
            tail_vld_d = 1'b0;
            if (push) begin
                if (tail_vld_q) begin
                    tail_d     = scl_q;
                    tail_vld_d = 1'b1;
                end else begin
                    head_d     = scl_q;
                    head_vld_d = 1'b1;
                end
            end
        end else if (push) begin
            if (!head_vld_q) begin
                head_d     = scl_q;
                head_vld_d = 1'b1;
            end else if (!tail_vld_q) begin
                tail_d     = scl_q;
                tail_vld_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tap_q      <= '0;
            acc_q      <= '0;
            cmp_q      <= 1'b0;
            scl_q      <= '0;
            scl_vld_q  <= 1'b0;
            scl_clip_q <= 1'b0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
            tail_q     <= '0;
            tail_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            tap_q      <= tap_d;
            acc_q      <= acc_d;
            cmp_q      <= cmp_d;
            scl_q      <= scl_d;
            scl_vld_q  <= scl_vld_d;
            scl_clip_q <= scl_clip_d;
            head_q     <= head_d;
            head_vld_q <= head_vld_d;
            tail_q     <= tail_d;
            tail_vld_q <= tail_vld_d;
            ovf_q      <= ovf_d;
            sat_q      <= sat_d;
        end
    end

    assign sample_out   = head_q;
    assign sample_valid = head_vld_q;
    assign overflow     = ovf_q;
    assign saturated    = sat_q;

endmodule

// File: doc/fir_accumulator.md
FIR_ACCUMULATOR -- requirements
Module: fir_accumulator

Interface
REQ-001 Parameter NUM_TAPS, default 16: products summed per output sample; legal range 2..256.
REQ-002 Parameter SHIFT, default 24: arithmetic right shift applied to the final sum before saturation; legal range 0..40.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 valid_in  input  1  product_in valid this cycle (no backpressure upstream).
REQ-006 product_in  input  48  signed tap product from the MAC cell pipeline.
REQ-007 flush  input  1  abandon the partial frame and restart at tap 0.
REQ-008 sample_out  output  18  signed filtered sample, head of the output FIFO.
REQ-009 sample_valid  output  1  sample_out holds a valid sample.
REQ-010 sample_ready  input  1  downstream accepts sample_out when sample_valid is high.
REQ-011 overflow  output  1  sticky: a completed sample was dropped because the FIFO was full.
REQ-012 saturated  output  1  sticky: at least one output sample was clipped.

Function
REQ-013 Accumulator width SHALL be 48+clog2(NUM_TAPS) bits, signed; product_in is sign-extended to this width.
REQ-014 Tap counter SHALL run 0..NUM_TAPS-1 and advance by one on each valid_in; no change without valid_in.
REQ-015 valid_in at tap 0: acc <= product_in; at any other tap: acc <= acc + product_in.
REQ-016 valid_in at tap NUM_TAPS-1: counter wraps to 0 and the frame is marked complete.
REQ-017 Scale stage, one cycle after completion: arithmetic right shift of acc by SHIFT (rounding per REQ-030/031), then saturation to [-131072, 131071]; the result is pushed into the output FIFO.
REQ-018 Latency: final product sampled at edge k -> sample_valid high after edge k+2 when the FIFO is empty.
REQ-019 Back-to-back frames with valid_in high every cycle SHALL be sustained with no lost products.
REQ-020 Output FIFO SHALL be 2 entries deep; a pop occurs on any cycle with sample_valid and sample_ready both high.
REQ-021 Push when FIFO full without a simultaneous pop: sample discarded, overflow set; FIFO contents unchanged.
REQ-022 Push and pop in the same cycle with FIFO full: both SHALL take effect; no overflow.
REQ-023 sample_out and sample_valid SHALL be driven from registers only, with no combinational path from sample_ready.
REQ-024 flush SHALL reset the tap counter to 0 and cancel any incomplete frame; frames already in the scale stage or FIFO are unaffected.
REQ-025 flush and valid_in in the same cycle: product_in is taken as tap 0 of a new frame.
REQ-026 saturated SHALL be set on any clipped push, including a push that REQ-021 drops.

Reset
REQ-027 reset SHALL override all other inputs in the same cycle.
REQ-028 On reset: tap counter = 0, acc = 0, scale stage empty, FIFO empty, sample_valid = 0, sample_out = 0, overflow = 0, saturated = 0.
REQ-029 Reset mid-frame SHALL discard the partial sum; the first valid_in after reset is tap 0.

Configuration
REQ-030 With FIR_ACC_ROUND_EN defined, 2^(SHIFT-1) SHALL be added before the shift (round half up); no addition when SHIFT=0.
REQ-031 Without FIR_ACC_ROUND_EN, the shift SHALL truncate toward negative infinity; there is no adder in the scale stage.

Verification
REQ-032 NUM_TAPS=4, SHIFT=0, products 1,2,3,4 on consecutive cycles, ready=1 -> sample_out=10, sample_valid for exactly one cycle, 2 edges after the last product.
REQ-033 SHIFT=24, four products of 0x0000_0180_0000 -> sum 0x600_0000 -> 6 in both builds; products of 0x0000_0080_0000 -> sum 0x200_0000 -> 2 in both builds; one product of 0x0000_0080_0000 and three zeros -> sum 0x80_0000 -> 1 with FIR_ACC_ROUND_EN, 0 without.
REQ-034 SHIFT=0, four products of 100000 -> sample_out=131071, saturated=1; four of -100000 -> -131072.
REQ-035 sample_ready=0, three complete frames -> first two retained in order, third dropped, overflow=1; then ready=1 -> exactly two samples drained.
REQ-036 flush asserted with valid_in after 2 of 4 taps (products 5,5 then 7,1,1,1) -> sample_out=10, not 20.
REQ-037 reset asserted after tap 2, then 4 products of 3 -> sample_out=12, both sticky flags 0.
